// File: rtl/dice_pkg.sv
// Shared types and display constants for the electronic dice: FSM state encoding,
// face-to-segment patterns and small face helpers.
package dice_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSpin,
    StSlow,
    StShow
  } dice_state_e;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SegBlank = 7'b0000000;
  localparam logic [6:0] SegFace0 = 7'b0000110;
  localparam logic [6:0] SegFace1 = 7'b1011011;
  localparam logic [6:0] SegFace2 = 7'b1001111;
  localparam logic [6:0] SegFace3 = 7'b1100110;
  localparam logic [6:0] SegFace4 = 7'b1101101;
  localparam logic [6:0] SegFace5 = 7'b1111101;

  function automatic logic [6:0] face_to_seg(input logic [2:0] face);
    logic [6:0] seg;
    case (face)
      3'd0:    seg = SegFace0;
      3'd1:    seg = SegFace1;
      3'd2:    seg = SegFace2;
      3'd3:    seg = SegFace3;
      3'd4:    seg = SegFace4;
      3'd5:    seg = SegFace5;
      default: seg = SegBlank;
    endcase
    return seg;
  endfunction

  function automatic logic [2:0] face_inc(input logic [2:0] face);
    return (face >= 3'd5) ? 3'd0 : face + 3'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, input register and a stability-count
// debouncer producing the accepted level and a one-cycle press pulse.
module btn_debounce
  import dice_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYC = 16'd50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic btn_db,
  output logic press
);

  // [1:0] synchronizer, [2] registered level fed to the comparator.
  logic [2:0]  sync_q, sync_d;
  logic [15:0] cnt_q, cnt_d;
  logic        db_q, db_d;
  logic        press_q, press_d;
  logic        lvl;

  assign lvl = sync_q[2];

  always_comb begin
    sync_d  = {sync_q[1:0], btn_i};
    cnt_d   = '0;
    db_d    = db_q;
    press_d = 1'b0;
    if (lvl != db_q) begin
      if (cnt_q == DEBOUNCE_CYC - 16'd1) begin
        db_d    = lvl;
        press_d = lvl;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // Chain resets high to match btn_db, so a button held through reset stays accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      db_q    <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      press_q <= press_d;
    end
  end

  assign btn_db = db_q;
  assign press  = press_q;

endmodule

// File: rtl/dice_roll_ctrl.sv
// Dice roll sequencer: spins the face while the debounced button is held, decelerates
// through doubling intervals after release, then holds the result before re-arming.
module dice_roll_ctrl
  import dice_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYC = 16'd50000,
  parameter logic [7:0]  FAST_DIV     = 8'd8,
  parameter int unsigned SLOW_STEPS   = 4,
  parameter logic [23:0] SHOW_CYC     = 24'd1000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN,
  output logic [2:0] FACE,
  output logic [6:0] DICE,
  output logic       ROLLING,
  output logic       DONE,
  output logic [7:0] ROLL_COUNT
);

  localparam int unsigned IvlW  = 8 + SLOW_STEPS;
  localparam int unsigned TmrW  = 24;
  localparam int unsigned StepW = 4;

  localparam logic [TmrW-1:0]  FastLast = TmrW'(FAST_DIV - 8'd1);
  localparam logic [TmrW-1:0]  ShowLast = SHOW_CYC - 24'd1;
  localparam logic [StepW-1:0] StepLast = StepW'(SLOW_STEPS - 1);

  logic btn_db;
  logic press;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn_debounce (
    .clk_i (CLK),
    .rst_i (RESET),
    .btn_i (BTN),
    .btn_db(btn_db),
    .press (press)
  );

  dice_state_e      state_q, state_d;
  logic [2:0]       face_q, face_d;
  logic [6:0]       dice_q, dice_d;
  logic             blank_q, blank_d;
  logic             rolling_q, rolling_d;
  logic             done_q, done_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [IvlW-1:0]  ivl_q, ivl_d;
  logic [StepW-1:0] step_q, step_d;
  logic [TmrW-1:0]  ivl_last;

  assign ivl_last = TmrW'(ivl_q - IvlW'(1));

  always_comb begin
    state_d = state_q;
    face_d  = face_q;
    blank_d = blank_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    ivl_d   = ivl_q;
    step_d  = step_q;
    unique case (state_q)
      StIdle: begin
        if (press) begin
          state_d = StSpin;
          blank_d = 1'b0;
          tmr_d   = '0;
        end
      end
      StSpin: begin
        // Release wins over a coincident divider expiry; the partial count is dropped.
        if (!btn_db) begin
          state_d = StSlow;
          tmr_d   = '0;
          ivl_d   = IvlW'(FAST_DIV);
          step_d  = '0;
        end else if (tmr_q == FastLast) begin
          tmr_d  = '0;
          face_d = face_inc(face_q);
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StSlow: begin
        if (tmr_q == ivl_last) begin
          tmr_d  = '0;
          face_d = face_inc(face_q);
          ivl_d  = ivl_q << 1;
          step_d = step_q + StepW'(1);
          if (step_q == StepLast) begin
            state_d = StShow;
            done_d  = 1'b1;
            cnt_d   = cnt_q + 8'd1;
          end
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StShow: begin
        if (tmr_q == ShowLast) begin
          state_d = StIdle;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    rolling_d = (state_d == StSpin) || (state_d == StSlow);
    dice_d    = blank_d ? SegBlank : face_to_seg(face_d);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      face_q    <= '0;
      dice_q    <= SegBlank;
      blank_q   <= 1'b1;
      rolling_q <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      ivl_q     <= '0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      face_q    <= face_d;
      dice_q    <= dice_d;
      blank_q   <= blank_d;
      rolling_q <= rolling_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      ivl_q     <= ivl_d;
      step_q    <= step_d;
    end
  end

  assign FACE       = face_q;
  assign DICE       = dice_q;
  assign ROLLING    = rolling_q;
  assign DONE       = done_q;
  assign ROLL_COUNT = cnt_q;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Bench for dice_roll_ctrl: an event-time model of the roll compared every cycle,
// plus hand-computed checkpoints along directed button sequences.
module tb_dice_roll_ctrl;

  localparam int DB   = 4;
  localparam int FD   = 2;
  localparam int NS   = 3;
  localparam int SHOW = 8;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       BTN = 1'b0;
  logic [2:0] FACE;
  logic [6:0] DICE;
  logic       ROLLING;
  logic       DONE;
  logic [7:0] ROLL_COUNT;

  int checks = 0;
  int failures = 0;

  dice_roll_ctrl #(
    .DEBOUNCE_CYC(16'd4),
    .FAST_DIV    (8'd2),
    .SLOW_STEPS  (3),
    .SHOW_CYC    (24'd8)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BTN       (BTN),
    .FACE      (FACE),
    .DICE      (DICE),
    .ROLLING   (ROLLING),
    .DONE      (DONE),
    .ROLL_COUNT(ROLL_COUNT)
  );

  always #5 CLK = ~CLK;

  logic [6:0] seg_tab [6] = '{7'b0000110, 7'b1011011, 7'b1001111,
                              7'b1100110, 7'b1101101, 7'b1111101};

  // Model: modes 0 idle, 1 spin, 2 slow, 3 show; timings from entry edge numbers.
  bit   m_samp[$];
  bit   m_db, m_press, m_prev, m_diff, m_blank, m_done, m_valid;
  int   m_mode, m_face, m_t0, m_k, m_cyc;
  logic [7:0] m_cnt;

  always @(posedge CLK) begin
    m_cyc++;
    if (RESET) begin
      m_samp.delete();
      for (int i = 0; i < 3 + DB; i++) m_samp.push_back(1'b1);
      m_db = 1'b1; m_press = 1'b0; m_mode = 0; m_face = 0; m_blank = 1'b1;
      m_done = 1'b0; m_cnt = 8'd0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_done = 1'b0;
      case (m_mode)
        0: if (m_press) begin m_mode = 1; m_t0 = m_cyc; m_blank = 1'b0; end
        1: begin
          if (!m_db) begin
            m_mode = 2; m_t0 = m_cyc; m_k = 0;
          end else if ((m_cyc - m_t0) % FD == 0) begin
            m_face = (m_face + 1) % 6;
          end
        end
        2: begin
          if (m_cyc - m_t0 == FD * ((1 << (m_k + 1)) - 1)) begin
            m_face = (m_face + 1) % 6;
            m_k++;
            if (m_k == NS) begin
              m_mode = 3; m_t0 = m_cyc; m_done = 1'b1; m_cnt = m_cnt + 8'd1;
            end
          end
        end
        default: if (m_cyc - m_t0 == SHOW) m_mode = 0;
      endcase
      // Accepted level flips once the last DB levels seen (BTN delayed 3 edges) all differ.
      m_samp.push_back(BTN);
      m_prev = m_db;
      m_diff = 1'b1;
      for (int j = 0; j < DB; j++)
        if (m_samp[m_samp.size() - 4 - j] == m_db) m_diff = 1'b0;
      if (m_diff) m_db = !m_db;
      m_press = !m_prev && m_db;
      if (m_samp.size() > 64) void'(m_samp.pop_front());
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      logic [6:0] exp_dice;
      exp_dice = m_blank ? 7'b0000000 : seg_tab[m_face];
      checks++;
      if (FACE !== 3'(m_face) || DICE !== exp_dice || DONE !== m_done ||
          ROLLING !== (m_mode == 1 || m_mode == 2) || ROLL_COUNT !== m_cnt) begin
        failures++;
        $display("FAIL cycle%0d: got face=%0d dice=%b rolling=%b done=%b count=%0d required face=%0d dice=%b rolling=%b done=%b count=%0d",
                 m_cyc, FACE, DICE, ROLLING, DONE, ROLL_COUNT, m_face, exp_dice,
                 (m_mode == 1 || m_mode == 2), m_done, m_cnt);
      end
    end
  end

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic btn_for(input bit lvl, input int n);
    BTN = lvl;
    wait_edges(n);
  endtask

  task automatic roll_once();
    btn_for(1'b1, 8);
    btn_for(1'b0, 32);
  endtask

  initial begin
    // Reset with the button low.
    wait_edges(3);
    chk("rst_face", FACE, 0);
    chk("rst_dice", DICE, 0);
    chk("rst_rolling", ROLLING, 0);
    chk("rst_done", DONE, 0);
    chk("rst_count", ROLL_COUNT, 0);
    RESET = 1'b0;
    btn_for(1'b0, 30);
    chk("idle_dice", DICE, 0);
    chk("idle_rolling", ROLLING, 0);

    // Main roll: BTN sampled high at edges 0..19.
    BTN = 1'b1;
    wait_edges(7);
    chk("pre_spin_rolling", ROLLING, 0);
    wait_edges(1);
    chk("spin_rolling", ROLLING, 1);
    chk("spin_dice", DICE, 7'b0000110);
    wait_edges(2);
    chk("first_advance", FACE, 1);
    chk("first_advance_dice", DICE, 7'b1011011);
    wait_edges(10);
    BTN = 1'b0;
    wait_edges(7);
    chk("release_face", FACE, 3);
    wait_edges(14);
    chk("pre_final_face", FACE, 5);
    chk("pre_final_done", DONE, 0);
    wait_edges(1);
    chk("final_done", DONE, 1);
    chk("final_face", FACE, 0);
    chk("final_rolling", ROLLING, 0);
    chk("final_count", ROLL_COUNT, 1);
    chk("final_dice", DICE, 7'b0000110);
    wait_edges(1);
    chk("done_pulse_end", DONE, 0);
    wait_edges(20);

    // Bounce rejected, then a 4-cycle stable pulse rolls.
    btn_for(1'b1, 3);
    btn_for(1'b0, 1);
    btn_for(1'b1, 2);
    btn_for(1'b0, 20);
    chk("bounce_rolling", ROLLING, 0);
    chk("bounce_face", FACE, 0);
    btn_for(1'b1, 4);
    BTN = 1'b0;
    wait_edges(4);
    chk("pulse4_rolling", ROLLING, 1);
    wait_edges(40);
    chk("pulse4_count", ROLL_COUNT, 2);

    // Presses during SLOW and during SHOW are dropped.
    btn_for(1'b1, 10);
    btn_for(1'b0, 4);
    btn_for(1'b1, 6);
    btn_for(1'b0, 8);
    btn_for(1'b1, 6);
    btn_for(1'b0, 40);
    chk("ignored_count", ROLL_COUNT, 3);
    chk("ignored_rolling", ROLLING, 0);
    roll_once();
    chk("next_roll_count", ROLL_COUNT, 4);

    // Reset mid-spin with the button held.
    BTN = 1'b1;
    wait_edges(10);
    chk("spin_before_rst", ROLLING, 1);
    RESET = 1'b1;
    wait_edges(2);
    chk("midrst_rolling", ROLLING, 0);
    chk("midrst_dice", DICE, 0);
    chk("midrst_count", ROLL_COUNT, 0);
    RESET = 1'b0;
    btn_for(1'b1, 30);
    chk("held_no_roll", ROLLING, 0);
    chk("held_dice_blank", DICE, 0);
    btn_for(1'b0, 20);
    roll_once();
    chk("after_rst_count", ROLL_COUNT, 1);

    // Counter wrap over 256 rolls.
    RESET = 1'b1;
    wait_edges(2);
    RESET = 1'b0;
    btn_for(1'b0, 20);
    for (int r = 0; r < 255; r++) roll_once();
    chk("count_255", ROLL_COUNT, 255);
    roll_once();
    chk("count_wrap", ROLL_COUNT, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
